// File: rtl/transmission_arbiter.sv
// ============================================================================
// transmission_arbiter
// ----------------------------------------------------------------------------
// Shares one serial transmitter between N_REQ requesters. When the block is
// idle and the transmitter is free, one requester is picked round-robin, its
// word and the current prescaler value are latched, and a start request is
// raised towards the transmitter. The block then follows the transmitter
// busy flag through the shift. It signals completion (done_o) or a start
// timeout (err_o) back to the owner with a single-cycle pulse.
//
// Ports
//   clk_i         in   1                     clock
//   reset_i       in   1                     synchronous active-high reset
//   req_i         in   N_REQ                 per-requester transmit request (level)
//   data_i        in   N_REQ*DATA_WIDTH      requester k word at [k*DATA_WIDTH +: DATA_WIDTH]
//   prescl_cfg_i  in   PRSCL_WIDTH           prescaler value for the next transaction
//   grant_o       out  N_REQ                 one-hot transmitter owner, zero when idle
//   done_o        out  N_REQ                 one-cycle completion pulse to the owner
//   err_o         out  N_REQ                 one-cycle timeout pulse to the owner
//   busy_o        out  1                     high whenever the FSM is not idle
//   tx_data_o     out  DATA_WIDTH            word to the transmitter
//   tx_prescl_o   out  PRSCL_WIDTH           prescaler value to the transmitter
//   tx_start_o    out  1                     start request to the transmitter
//   tx_busy_i     in   1                     transmitter busy for the whole shift
// ============================================================================
module transmission_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int PRSCL_WIDTH = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
    input  logic [PRSCL_WIDTH-1:0]      prescl_cfg_i,
    output logic [N_REQ-1:0]            grant_o,
    output logic [N_REQ-1:0]            done_o,
    output logic [N_REQ-1:0]            err_o,
    output logic                        busy_o,
    output logic [DATA_WIDTH-1:0]       tx_data_o,
    output logic [PRSCL_WIDTH-1:0]      tx_prescl_o,
    output logic                        tx_start_o,
    input  logic                        tx_busy_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_e;

    state_e                 state_q,      state_d;
    logic [N_REQ-1:0]       grant_q,      grant_d;
    logic [N_REQ-1:0]       done_q,       done_d;
    logic [N_REQ-1:0]       err_q,        err_d;
    logic                   tx_start_q,   tx_start_d;
    logic [DATA_WIDTH-1:0]  tx_data_q,    tx_data_d;
    logic [PRSCL_WIDTH-1:0] tx_prescl_q,  tx_prescl_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [IDX_W-1:0]       owner_q,      owner_d;

    logic                   win_found_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [IDX_W:0]         cand_s;

    // Round-robin search: first requester at or after (last_grant + 1), wrapping.
    // cand_s has one spare bit so the sum never overflows before the wrap.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = {1'b0, last_grant_q} + (IDX_W+1)'(1) + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(N_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req_i[cand_s[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = '0;
        err_d        = '0;
        tx_start_d   = tx_start_q;
        tx_data_d    = tx_data_q;
        tx_prescl_d  = tx_prescl_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;

        case (state_q)
            ST_IDLE: begin
                // A busy transmitter blocks any new grant.
                if (win_found_s && !tx_busy_i) begin
                    state_d     = ST_START;
                    grant_d     = N_REQ'(1) << win_idx_s;
                    owner_d     = win_idx_s;
                    tx_data_d   = data_i[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    tx_prescl_d = prescl_cfg_i;
                    tx_start_d  = 1'b1;
                    cnt_d       = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_busy_i) begin
                    state_d    = ST_RUN;
                    tx_start_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = ST_ABORT;
                    tx_start_d   = 1'b0;
                    grant_d      = '0;
                    err_d        = grant_q;
                    last_grant_d = owner_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // The owner's req_i is not looked at here: a dropped request
                // still lets the shift finish and report done.
                if (!tx_busy_i) begin
                    state_d      = ST_DONE;
                    done_d       = grant_q;
                    grant_d      = '0;
                    last_grant_d = owner_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                tx_start_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset gives requester 0 first priority.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            err_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_prescl_q  <= '0;
            cnt_q        <= '0;
            last_grant_q <= IDX_W'(N_REQ - 1);
            owner_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            err_q        <= err_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            tx_prescl_q  <= tx_prescl_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign tx_data_o   = tx_data_q;
    assign tx_prescl_o = tx_prescl_q;
    assign tx_start_o  = tx_start_q;

endmodule

// File: tb/tb_transmission_arbiter.sv
// Directed bench for transmission_arbiter with a transaction scoreboard.
module tb_transmission_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int PW  = 8;
    localparam int TMO = 1024;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [NR-1:0]    req_i;
    logic [NR*DW-1:0] data_i;
    logic [PW-1:0]    prescl_cfg_i;
    logic [NR-1:0]    grant_o, done_o, err_o;
    logic             busy_o, tx_start_o;
    logic [DW-1:0]    tx_data_o;
    logic [PW-1:0]    tx_prescl_o;
    logic             tx_busy_i;

    always #5 clk = ~clk;

    transmission_arbiter #(
        .N_REQ(NR), .DATA_WIDTH(DW), .PRSCL_WIDTH(PW), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .data_i(data_i),
        .prescl_cfg_i(prescl_cfg_i), .grant_o(grant_o), .done_o(done_o),
        .err_o(err_o), .busy_o(busy_o), .tx_data_o(tx_data_o),
        .tx_prescl_o(tx_prescl_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i)
    );

    typedef struct {
        logic [NR-1:0] grant;
        logic [DW-1:0] data;
        logic [PW-1:0] prescl;
        bit            is_err;
        int            starts;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;
    int   done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [NR-1:0] g, input logic [DW-1:0] d,
                        input logic [PW-1:0] p, input bit e, input int s);
        exp_t x;
        x.grant = g; x.data = d; x.prescl = p; x.is_err = e; x.starts = s;
        sb_q.push_back(x);
    endtask

    // Transmitter model: busy rises after 3 start cycles and stays 40 cycles.
    logic model_mode = 1'b0;
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    int   sc = 0;
    int   hold = 0;
    assign tx_busy_i = model_mode ? model_busy : force_busy;

    always @(negedge clk) begin
        if (reset_i || !model_mode) begin
            model_busy = 1'b0; sc = 0; hold = 0;
        end else if (model_busy) begin
            hold++;
            if (hold >= 40) begin model_busy = 1'b0; hold = 0; end
        end else if (tx_start_o) begin
            sc++;
            if (sc == 3) begin model_busy = 1'b1; sc = 0; end
        end
    end

    // Monitor: checks each new grant and each done/err pulse against the scoreboard.
    logic [NR-1:0] prev_grant = '0;
    int            start_cnt  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (grant_o != '0 && prev_grant == '0) begin
            start_cnt = 0;
            if (sb_q.size() == 0) begin
                check("unexpected_grant", 32'(grant_o), 32'(0));
            end else begin
                check("grant", 32'(grant_o), 32'(sb_q[0].grant));
                check("tx_data", 32'(tx_data_o), 32'(sb_q[0].data));
                check("tx_prescl", 32'(tx_prescl_o), 32'(sb_q[0].prescl));
            end
        end
        if (tx_start_o) start_cnt++;
        if (grant_o != '0 && sb_q.size() > 0 && !tx_start_o)
            check("data_stable", 32'(tx_data_o), 32'(sb_q[0].data));
        if (done_o != '0 || err_o != '0) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'({done_o, err_o}), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("done", 32'(done_o), e.is_err ? 32'(0) : 32'(e.grant));
                check("err", 32'(err_o), e.is_err ? 32'(e.grant) : 32'(0));
                check("start_cycles", 32'(start_cnt), 32'(e.starts));
                check("grant_cleared", 32'(grant_o), 32'(0));
                check("end_data", 32'(tx_data_o), 32'(e.data));
            end
        end
        prev_grant = grant_o;
    end

    task automatic wait_done(input int target, input int budget, input bit drop);
        int n;
        n = 0;
        while (done_seen < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (drop) req_i = '0;
        check("wait_done", 32'(done_seen), 32'(target));
    endtask

    task automatic wait_run(input int budget);
        int  n;
        bit  ok;
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk); #1;
            n++;
            ok = busy_o && !tx_start_o && (grant_o != '0);
        end
        check("wait_run", 32'(ok), 32'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant_o), 32'(0));
        check({tag, "_done"}, 32'(done_o), 32'(0));
        check({tag, "_err"}, 32'(err_o), 32'(0));
        check({tag, "_busy"}, 32'(busy_o), 32'(0));
        check({tag, "_start"}, 32'(tx_start_o), 32'(0));
        check({tag, "_data"}, 32'(tx_data_o), 32'(0));
        check({tag, "_prescl"}, 32'(tx_prescl_o), 32'(0));
    endtask

    initial begin
        int base;
        int n;
        reset_i      = 1'b1;
        req_i        = '0;
        data_i       = {8'h3C, 8'h5A, 8'hC3, 8'hA5};
        prescl_cfg_i = 8'h10;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset_i    = 1'b0;
        model_mode = 1'b1;
        @(negedge clk); #1;

        // Contention: all four requesting, order 0,1,2,3,0.
        push(4'b0001, 8'hA5, 8'h10, 1'b0, 3);
        push(4'b0010, 8'hC3, 8'h10, 1'b0, 3);
        push(4'b0100, 8'h5A, 8'h10, 1'b0, 3);
        push(4'b1000, 8'h3C, 8'h10, 1'b0, 3);
        push(4'b0001, 8'hA5, 8'h10, 1'b0, 3);
        base  = done_seen;
        req_i = 4'b1111;
        wait_done(base + 5, 400, 1'b1);
        check("contention_sb_empty", 32'(sb_q.size()), 32'(0));
        repeat (2) @(negedge clk); #1;

        // Single request.
        push(4'b0001, 8'hA5, 8'h10, 1'b0, 3);
        base  = done_seen;
        req_i = 4'b0001;
        wait_done(base + 1, 100, 1'b1);
        repeat (2) @(negedge clk); #1;

        // Timeout: transmitter never goes busy.
        model_mode = 1'b0;
        force_busy = 1'b0;
        prescl_cfg_i = 8'h44;
        push(4'b0100, 8'h5A, 8'h44, 1'b1, TMO);
        req_i = 4'b0100;
        n = 0;
        while (grant_o == '0 && n < 20) begin @(negedge clk); #1; n++; end
        req_i = '0;
        n = 0;
        while (err_o == '0 && n < TMO + 20) begin @(negedge clk); #1; n++; end
        check("timeout_cycles", 32'(n), 32'(TMO));
        @(negedge clk); #1;
        check("abort_busy_low", 32'(busy_o), 32'(0));
        check("abort_no_err_repeat", 32'(err_o), 32'(0));

        // Resource guard: transmitter busy while idle.
        prescl_cfg_i = 8'h22;
        force_busy   = 1'b1;
        push(4'b0010, 8'hC3, 8'h22, 1'b0, 3);
        base  = done_seen;
        req_i = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("guard_no_grant", 32'(grant_o), 32'(0));
        end
        force_busy = 1'b0;
        model_mode = 1'b1;
        @(negedge clk); #1;
        check("guard_grant", 32'(grant_o), 32'(4'b0010));
        wait_done(base + 1, 100, 1'b1);
        repeat (2) @(negedge clk); #1;

        // Owner drops req and data_i changes during RUN.
        prescl_cfg_i = 8'h33;
        push(4'b1000, 8'h3C, 8'h33, 1'b0, 3);
        base  = done_seen;
        req_i = 4'b1000;
        wait_run(20);
        req_i  = '0;
        data_i = ~data_i;
        wait_done(base + 1, 100, 1'b0);
        data_i = {8'h3C, 8'h5A, 8'hC3, 8'hA5};
        repeat (2) @(negedge clk); #1;

        // Reset mid-RUN.
        push(4'b0100, 8'h5A, 8'h33, 1'b0, 3);
        base  = done_seen;
        req_i = 4'b0100;
        wait_run(20);
        req_i   = '0;
        reset_i = 1'b1;
        sb_q.delete();
        @(negedge clk); #1;
        check_all_zero("mid_reset");
        reset_i = 1'b0;
        repeat (50) @(negedge clk); #1;
        check("no_done_after_reset", 32'(done_seen), 32'(base));

        // After reset requester 0 wins over 3, then 3 follows.
        push(4'b0001, 8'hA5, 8'h33, 1'b0, 3);
        push(4'b1000, 8'h3C, 8'h33, 1'b0, 3);
        req_i = 4'b1001;
        wait_done(base + 2, 200, 1'b1);
        check("final_sb_empty", 32'(sb_q.size()), 32'(0));
        repeat (3) @(negedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/transmission_arbiter.md
TRANSMISSION_ARBITER -- requirements
Module: transmission_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_REQ, 4, number of requesters
- DATA_WIDTH, 8, transmit word width
- PRSCL_WIDTH, 8, prescaler value width
- TIMEOUT, 1024, clk_i cycles allowed from start assertion to tx_busy_i rising
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single clock for all logic
- reset_i, in, 1, synchronous active-high reset
- req_i, in, N_REQ, per-requester transmit request, level
- data_i, in, N_REQ*DATA_WIDTH, requester k word at bits [k*DATA_WIDTH +: DATA_WIDTH]
- prescl_cfg_i, in, PRSCL_WIDTH, prescaler value for the next transaction
- grant_o, out, N_REQ, one-hot owner of the transmitter; all-zero when idle
- done_o, out, N_REQ, one-cycle completion pulse to the owner
- err_o, out, N_REQ, one-cycle timeout pulse to the owner
- busy_o, out, 1, high whenever state is not IDLE
- tx_data_o, out, DATA_WIDTH, word to the transmitter
- tx_prescl_o, out, PRSCL_WIDTH, prescaler value to the transmitter
- tx_start_o, out, 1, start request to the transmitter
- tx_busy_i, in, 1, transmitter busy, high for the whole shift
REQ-003 The block SHALL use one clock, clk_i; reset_i SHALL be synchronous and active-high.

Function
REQ-004 The state machine SHALL have states IDLE, START, RUN and DONE, plus ABORT.
REQ-005 In IDLE, when req_i is nonzero and tx_busy_i=0, the block SHALL:
- pick the winner round-robin, searching from (last_grant+1) mod N_REQ upward with wrap
- set grant_o one-hot for the winner
- capture the winner's data_i slice into tx_data_o and prescl_cfg_i into tx_prescl_o
- go to START on the same edge
REQ-006 While tx_busy_i=1 in IDLE, no grant SHALL be issued (resource guard).
REQ-007 START behaviour:
- tx_start_o SHALL be 1
- timeout counter SHALL clear on entry and increment each cycle
- tx_busy_i=1 SHALL move the state to RUN, with tx_start_o low from the next cycle
REQ-008 If the counter reaches TIMEOUT-1 in START with tx_busy_i still 0, the state SHALL go to ABORT.
REQ-009 ABORT SHALL, for one cycle:
- pulse err_o for the owner
- drop tx_start_o and grant_o
- update last_grant
- return to IDLE with no done_o pulse
REQ-010 RUN SHALL wait for tx_busy_i=0, then go to DONE.
REQ-011 DONE SHALL, for one cycle:
- pulse done_o for the owner
- clear grant_o
- set last_grant to the owner
- return to IDLE
REQ-012 tx_data_o and tx_prescl_o SHALL be held constant from entry to START until exit from RUN; they are unchanged in IDLE.
REQ-013 The owner dropping req_i mid-transaction SHALL NOT abort it; the transfer completes and done_o still pulses.
REQ-014 req_i still high in the IDLE cycle after done_o SHALL be treated as a new request; minimum grant-to-grant gap is 1 IDLE cycle.
REQ-015 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester waits more than N_REQ-1 transactions.
REQ-016 A requester asserting req_i during another's transaction SHALL be arbitrated only in IDLE.
REQ-017 At most one bit of grant_o, done_o and err_o SHALL be set in any cycle; done_o and err_o SHALL never pulse together.

Reset
REQ-018 On a clk_i edge with reset_i=1, the block SHALL drive:
- state IDLE
- grant_o, done_o, err_o = 0
- busy_o, tx_start_o = 0
- tx_data_o, tx_prescl_o = 0
- timeout counter = 0
- last_grant = N_REQ-1, so requester 0 has first priority
REQ-019 Reset in any state, including mid-RUN, SHALL take effect on that edge; no done_o or err_o SHALL pulse for the aborted transaction.

Verification
REQ-020 Single request: req_i=0001, data 0xA5, prescl 0x10; model raises tx_busy_i 3 cycles after start for 40 cycles -> expected:
- grant_o=0001, tx_data_o=0xA5, tx_prescl_o=0x10
- tx_start_o high 3 cycles
- done_o=0001 one cycle after tx_busy_i falls
REQ-021 Contention: req_i=1111 held through 5 transactions -> grant order 0,1,2,3,0; each done_o matches its grant.
REQ-022 Timeout: req_i=0100, tx_busy_i never rises -> expected:
- err_o=0100 exactly TIMEOUT cycles after START entry
- no done_o
- busy_o low the next cycle
REQ-023 Resource guard: tx_busy_i=1 while idle with req_i=0010 -> no grant until tx_busy_i=0, grant the following edge.
REQ-024 Reset mid-RUN: reset_i pulsed one cycle during RUN -> expected:
- all outputs 0 the next cycle
- no done_o
- subsequent req_i=1000 and 0001 together -> requester 0 granted first
REQ-025 Owner drops req_i during RUN -> transfer completes, done_o still pulses, and data stays stable throughout.
